serial_paralelo_rx: RTL
=======================

Name: serial_paralelo_rx

Overview:
- Receive-side counterpart of the team's parallel-to-serial transmitter.
- Takes the 1-bit, MSB-first serial stream at the bit clock and finds byte alignment by hunting for the 0xBC idle comma.
- Declares the link active after BC_LOCK consecutive aligned commas.
- From then on, presents each received byte in parallel with a valid flag: valid is 0 for idle 0xBC, 1 for data.

Parameters:
- COMMA, 8'hBC, idle/alignment character the transmitter sends when its valid_in is low.
- BC_LOCK, 4, number of consecutive aligned COMMA bytes (first one included) required to enter ACTIVE; legal range 1..15.

Ports:
- clk32_f  input  1  bit clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial bit, MSB of each byte first.
- data_out  output  8  last received byte while ACTIVE.
- valid_out  output  1  1 when data_out is a non-COMMA byte received in ACTIVE.
- byte_strobe  output  1  one-cycle pulse when data_out/valid_out update.
- active  output  1  link aligned and locked.

Behaviour:
- Reset (sampled on posedge, reset=1):
  - data_out=8'h00, valid_out=0, byte_strobe=0, active=0.
  - Shift register=0, bit_cnt=0, bc_cnt=0, state=SEARCH.
  - Reset is honoured in any state, including mid-byte in ACTIVE.
- Deserialisation:
  - Every cycle, sr <= {sr[6:0], data_in}.
  - The candidate word is cand = {sr[6:0], data_in}, i.e. the last 8 bits including the current one.
- Byte boundary: once aligned, bit_cnt counts 0..7 and wraps; a byte completes on a cycle with bit_cnt==7.
- SEARCH:
  - Bit-by-bit comparison of cand with COMMA every cycle.
  - On match: the byte completes this cycle; set bit_cnt=0 (next cycle is bit 0 of the next byte) and bc_cnt=1.
  - On match, if BC_LOCK==1 go to ACTIVE, else go to ALIGN.
  - On no match: stay in SEARCH.
  - Outputs stay at valid_out=0, byte_strobe=0, active=0; data_out holds its value.
- ALIGN:
  - Compare only at byte boundaries.
  - cand==COMMA: bc_cnt++. When bc_cnt reaches BC_LOCK, go to ACTIVE and set active=1 on the next cycle.
  - cand!=COMMA: go to SEARCH with bc_cnt=0. That same byte is not re-checked for a comma; the search resumes with the next bit.
  - No data_out, valid_out or byte_strobe activity in ALIGN.
- ACTIVE:
  - At each byte boundary, on the following clock: data_out<=cand, valid_out<=(cand!=COMMA), byte_strobe=1 for exactly one cycle.
  - data_out and valid_out hold between boundaries.
  - Latency: last bit of a byte sampled at edge N, so data_out/valid_out/byte_strobe are visible after edge N+1.
  - No realignment in ACTIVE: COMMA patterns straddling byte boundaries are ignored.
  - ACTIVE is left only via reset. active stays 1 until reset.
- Strobe period in ACTIVE: exactly 8 cycles.
- Width/wrap rules:
  - bit_cnt is 3 bits, wrapping 7->0.
  - bc_cnt is 4 bits and saturates at BC_LOCK; it is never used in ACTIVE.
- Simultaneous events: reset has priority over all comparisons. A comma match and a boundary in the same cycle in SEARCH is simply the match.

Test Plan:
- Reset 3 cycles, then stream 0xBC x4 followed by 0x5A, 0x01 MSB-first -> active rises 1 cycle after the 4th BC completes; the next two strobes, 8 cycles apart, show data_out=0x5A then 0x01 with valid_out=1.
- 3x 0xBC, then 0x00, then 4x 0xBC -> no lock after the first 3 (ALIGN returns to SEARCH on 0x00); active=1 only after the second run's 4th BC; no byte_strobe before active.
- 3 random bits 1,0,1, then 0xBC x4, then 0xA5 (stream misaligned by 3) -> lock achieved; data_out=0xA5, valid_out=1, strobe phase offset matches the 3-bit lead.
- In ACTIVE, send 0xBC between data bytes 0x11, 0xBC, 0x22 -> strobes show 0x11/v=1, 0xBC/v=0, 0x22/v=1.
- In ACTIVE, send 0x0B, 0xC0 (BC straddling the boundary) -> data_out=0x0B then 0xC0, valid_out=1 both, strobe period unchanged (no realign).
- Assert reset for 1 cycle mid-byte in ACTIVE -> next cycle active=0, valid_out=0, data_out=0x00; relock requires 4 fresh BCs.

Source files
------------

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: hunts for the idle comma, locks byte
// alignment after BC_LOCK aligned commas, then emits bytes with a valid flag.
module serial_paralelo_rx #(
    parameter logic [7:0]  COMMA   = 8'hBC,
    parameter int unsigned BC_LOCK = 4
) (
    input  logic       clk32_f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] LOCK = 4'(BC_LOCK);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] sr;
    logic [7:0] cand;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_nxt;
    logic [3:0] bc_cnt;
    logic [3:0] bc_cnt_nxt;
    logic [3:0] bc_inc;
    logic       match;
    logic       boundary;
    logic       pend;
    logic       pend_nxt;
    logic [7:0] pend_byte;
    logic       active_nxt;

    assign cand     = {sr[6:0], data_in};
    assign match    = (cand == COMMA);
    assign boundary = (bit_cnt == 3'd7);
    assign bc_inc   = bc_cnt + 4'd1;

    always_ff @(posedge clk32_f) begin
        if (reset) begin
            state       <= SEARCH;
            sr          <= 8'h00;
            bit_cnt     <= 3'd0;
            bc_cnt      <= 4'd0;
            pend        <= 1'b0;
            pend_byte   <= 8'h00;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_nxt;
            sr          <= cand;
            bit_cnt     <= bit_cnt_nxt;
            bc_cnt      <= bc_cnt_nxt;
            pend        <= pend_nxt;
            byte_strobe <= pend;
            active      <= active_nxt;
            if (pend_nxt) begin
                pend_byte <= cand;
            end
            // Bytes reach the outputs one clock after their boundary.
            if (pend) begin
                data_out  <= pend_byte;
                valid_out <= (pend_byte != COMMA);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt + 3'd1;
        bc_cnt_nxt  = bc_cnt;
        unique case (state)
            SEARCH: begin
                if (match) begin
                    bit_cnt_nxt = 3'd0;
                    bc_cnt_nxt  = 4'd1;
                    state_nxt   = (LOCK == 4'd1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (match) begin
                        if (bc_inc >= LOCK) begin
                            bc_cnt_nxt = LOCK;
                            state_nxt  = ACTIVE;
                        end else begin
                            bc_cnt_nxt = bc_inc;
                        end
                    end else begin
                        bc_cnt_nxt = 4'd0;
                        state_nxt  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                state_nxt = ACTIVE;
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase
    end

    always_comb begin
        pend_nxt   = (state == ACTIVE) && boundary;
        active_nxt = (state == ACTIVE);
    end

endmodule
